// File: rtl/store_buffer_pkg.sv
// Shared widths, funct3 encodings and the store-buffer entry layout.
package store_buffer_pkg;

    localparam int unsigned SB_ADDR_W    = 32;
    localparam int unsigned SB_DATA_W    = 32;
    localparam int unsigned SB_ROB_W     = 5;
    localparam int unsigned SB_DEPTH_DEF = 8;

    // Store sizes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    // Load sizes / sign
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic                 valid;
        logic                 committed;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [2:0]           funct3;
        logic [SB_ROB_W-1:0]  rob_id;
    } sb_entry_t;

    // Access size in bytes from funct3[1:0]
    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/sb_forward_unit.sv
// Store-to-load forwarding: youngest-first scan of buffered stores, byte
// extraction and sign/zero extension. Purely combinational.
// Ports: i_entries/i_head/i_count (buffer view), i_load_* (lookup request),
//        o_fwd_hit/o_fwd_data/o_fwd_stall (forwarding result).
module sb_forward_unit
    import store_buffer_pkg::*;
#(
    parameter int unsigned SB_DEPTH = SB_DEPTH_DEF,
    parameter int unsigned PTR_W    = $clog2(SB_DEPTH),
    parameter int unsigned CNT_W    = PTR_W + 1
) (
    input  sb_entry_t            i_entries [SB_DEPTH],
    input  logic [PTR_W-1:0]     i_head,
    input  logic [CNT_W-1:0]     i_count,
    input  logic                 i_load_valid,
    input  logic [SB_ADDR_W-1:0] i_load_addr,
    input  logic [2:0]           i_load_funct3,
    output logic                 o_fwd_hit,
    output logic [SB_DATA_W-1:0] o_fwd_data,
    output logic                 o_fwd_stall
);

    logic                 w_found;
    logic                 w_hit;
    logic                 w_stall;
    logic [PTR_W-1:0]     w_idx;
    sb_entry_t            w_e;
    logic [2:0]           w_s_off;
    logic [2:0]           w_s_end;
    logic [2:0]           w_l_off;
    logic [2:0]           w_l_end;
    logic [SB_DATA_W-1:0] w_shifted;
    logic                 w_unused;

    assign w_l_off = {1'b0, i_load_addr[1:0]};
    assign w_l_end = w_l_off + size_bytes(i_load_funct3);

    // First word-address match, scanning from tail-1 back to head, decides.
    always_comb begin
        w_found   = 1'b0;
        w_hit     = 1'b0;
        w_stall   = 1'b0;
        w_idx     = '0;
        w_e       = '0;
        w_s_off   = '0;
        w_s_end   = '0;
        w_shifted = '0;
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            w_idx = PTR_W'(32'(i_head) + 32'(i_count) - 32'd1 - k);
            w_e   = i_entries[w_idx];
            if (i_load_valid && !w_found && (k < 32'(i_count)) && w_e.valid &&
                (w_e.addr[SB_ADDR_W-1:2] == i_load_addr[SB_ADDR_W-1:2])) begin
                w_found = 1'b1;
                w_s_off = {1'b0, w_e.addr[1:0]};
                w_s_end = w_s_off + size_bytes(w_e.funct3);
                if ((w_s_off <= w_l_off) && (w_l_end <= w_s_end)) begin
                    w_hit     = 1'b1;
                    // Data is held unaligned: shift by the byte distance.
                    w_shifted = w_e.data >> {2'(i_load_addr[1:0] - w_e.addr[1:0]), 3'b000};
                end else begin
                    w_stall = 1'b1;
                end
            end
        end
    end

    // Extend the extracted bytes per load type.
    always_comb begin
        o_fwd_data = '0;
        if (w_hit) begin
            case (i_load_funct3)
                F3_LB:   o_fwd_data = {{(SB_DATA_W-8){w_shifted[7]}}, w_shifted[7:0]};
                F3_LH:   o_fwd_data = {{(SB_DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
                F3_LBU:  o_fwd_data = {{(SB_DATA_W-8){1'b0}}, w_shifted[7:0]};
                F3_LHU:  o_fwd_data = {{(SB_DATA_W-16){1'b0}}, w_shifted[15:0]};
                default: o_fwd_data = w_shifted;
            endcase
        end
    end

    assign o_fwd_hit   = w_hit;
    assign o_fwd_stall = w_stall;

    // Commit state and ROB ids play no part in forwarding.
    always_comb begin
        w_unused = 1'b0;
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            w_unused = w_unused ^ (^{i_entries[k].committed, i_entries[k].rob_id});
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Speculative store buffer: captures executed stores in order, commits them
// against the ROB, drains committed stores to memory, forwards to loads and
// discards uncommitted stores on flush.
// Ports: store_* (allocate), commit_* (retire), mem_* (drain handshake),
//        load_*/fwd_* (forwarding), flush, sb_full/sb_empty/commit_error status.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SB_ADDR_W,
    parameter int unsigned DATA_WIDTH = SB_DATA_W,
    parameter int unsigned ROB_WIDTH  = SB_ROB_W,
    parameter int unsigned SB_DEPTH   = SB_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  store_valid,
    input  logic [ADDR_WIDTH-1:0] store_waddr,
    input  logic [DATA_WIDTH-1:0] store_wdata,
    input  logic [2:0]            store_funct3,
    input  logic [ROB_WIDTH-1:0]  store_rob_id,
    input  logic                  commit_valid,
    input  logic [ROB_WIDTH-1:0]  commit_rob_id,
    output logic                  mem_wvalid,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_wfunct3,
    input  logic                  mem_wready,
    input  logic                  load_valid,
    input  logic [ADDR_WIDTH-1:0] load_raddr,
    input  logic [2:0]            load_funct3,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  fwd_stall,
    output logic                  sb_full,
    output logic                  sb_empty,
    output logic                  commit_error
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t        r_entry     [SB_DEPTH];
    sb_entry_t        w_entry_nxt [SB_DEPTH];
    logic [PTR_W-1:0] r_head, r_cmt, r_tail;
    logic [PTR_W-1:0] w_head_nxt, w_cmt_nxt, w_tail_nxt;
    logic [CNT_W-1:0] r_count, r_uncmt;
    logic [CNT_W-1:0] w_count_nxt, w_uncmt_nxt, w_uncmt_after;
    logic             r_commit_error;

    sb_entry_t        w_head_e;
    sb_entry_t        w_cmt_e;
    logic             w_alloc;
    logic             w_pop;
    logic             w_commit_ok;

    assign w_head_e = r_entry[r_head];
    assign w_cmt_e  = r_entry[r_cmt];

    assign sb_full      = (r_count == CNT_W'(SB_DEPTH));
    assign sb_empty     = (r_count == '0);
    assign commit_error = r_commit_error;

    assign mem_wvalid  = w_head_e.valid && w_head_e.committed;
    assign mem_waddr   = w_head_e.addr;
    assign mem_wdata   = w_head_e.data;
    assign mem_wfunct3 = w_head_e.funct3;

    // Full is judged on registered count, so a same-cycle pop never frees a slot.
    assign w_alloc     = store_valid && !sb_full && !flush;
    assign w_pop       = mem_wvalid && mem_wready;
    assign w_commit_ok = commit_valid && w_cmt_e.valid && !w_cmt_e.committed &&
                         (w_cmt_e.rob_id == commit_rob_id);

    // Per-entry next state: commit, then flush invalidation, then pop/alloc.
    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_entry_nxt[i] = r_entry[i];
            if (w_commit_ok && (PTR_W'(i) == r_cmt)) begin
                w_entry_nxt[i].committed = 1'b1;
            end
            if (flush && !w_entry_nxt[i].committed) begin
                w_entry_nxt[i].valid = 1'b0;
            end
            if (w_pop && (PTR_W'(i) == r_head)) begin
                w_entry_nxt[i] = '0;
            end
            if (w_alloc && (PTR_W'(i) == r_tail)) begin
                w_entry_nxt[i].valid     = 1'b1;
                w_entry_nxt[i].committed = 1'b0;
                w_entry_nxt[i].addr      = store_waddr;
                w_entry_nxt[i].data      = store_wdata;
                w_entry_nxt[i].funct3    = store_funct3;
                w_entry_nxt[i].rob_id    = store_rob_id;
            end
        end
    end

    // Pointer and occupancy update; r_uncmt tracks entries a flush would drop.
    always_comb begin
        w_head_nxt    = w_pop       ? r_head + PTR_W'(1) : r_head;
        w_cmt_nxt     = w_commit_ok ? r_cmt + PTR_W'(1)  : r_cmt;
        w_uncmt_after = r_uncmt - CNT_W'(w_commit_ok);
        if (flush) begin
            w_tail_nxt  = w_cmt_nxt;
            w_uncmt_nxt = '0;
            w_count_nxt = r_count - CNT_W'(w_pop) - w_uncmt_after;
        end else begin
            w_tail_nxt  = w_alloc ? r_tail + PTR_W'(1) : r_tail;
            w_uncmt_nxt = w_uncmt_after + CNT_W'(w_alloc);
            w_count_nxt = r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_head         <= '0;
            r_cmt          <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_uncmt        <= '0;
            r_commit_error <= 1'b0;
        end else begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_entry[i] <= w_entry_nxt[i];
            end
            r_head  <= w_head_nxt;
            r_cmt   <= w_cmt_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            r_uncmt <= w_uncmt_nxt;
            if (commit_valid && !w_commit_ok) begin
                r_commit_error <= 1'b1;
            end
        end
    end

    sb_forward_unit #(
        .SB_DEPTH (SB_DEPTH)
    ) u_fwd (
        .i_entries     (r_entry),
        .i_head        (r_head),
        .i_count       (r_count),
        .i_load_valid  (load_valid),
        .i_load_addr   (load_raddr),
        .i_load_funct3 (load_funct3),
        .o_fwd_hit     (fwd_hit),
        .o_fwd_data    (fwd_data),
        .o_fwd_stall   (fwd_stall)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: latency, forwarding, full/drop, flush,
// commit error and wrap-around ordering.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        store_valid;
    logic [31:0] store_waddr;
    logic [31:0] store_wdata;
    logic [2:0]  store_funct3;
    logic [4:0]  store_rob_id;
    logic        commit_valid;
    logic [4:0]  commit_rob_id;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_wfunct3;
    logic        mem_wready;
    logic        load_valid;
    logic [31:0] load_raddr;
    logic [2:0]  load_funct3;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_stall;
    logic        sb_full;
    logic        sb_empty;
    logic        commit_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .store_valid   (store_valid),
        .store_waddr   (store_waddr),
        .store_wdata   (store_wdata),
        .store_funct3  (store_funct3),
        .store_rob_id  (store_rob_id),
        .commit_valid  (commit_valid),
        .commit_rob_id (commit_rob_id),
        .mem_wvalid    (mem_wvalid),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .mem_wfunct3   (mem_wfunct3),
        .mem_wready    (mem_wready),
        .load_valid    (load_valid),
        .load_raddr    (load_raddr),
        .load_funct3   (load_funct3),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data),
        .fwd_stall     (fwd_stall),
        .sb_full       (sb_full),
        .sb_empty      (sb_empty),
        .commit_error  (commit_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f3, input logic [4:0] rob);
        store_valid  = 1'b1;
        store_waddr  = a;
        store_wdata  = d;
        store_funct3 = f3;
        store_rob_id = rob;
        tick();
        store_valid  = 1'b0;
    endtask

    task automatic do_commit(input logic [4:0] rob);
        commit_valid  = 1'b1;
        commit_rob_id = rob;
        tick();
        commit_valid  = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic hit, input logic stall, input logic [31:0] d);
        load_valid  = 1'b1;
        load_raddr  = a;
        load_funct3 = f3;
        #1;
        check({tag, "_hit"}, 32'(fwd_hit), 32'(hit));
        check({tag, "_stall"}, 32'(fwd_stall), 32'(stall));
        if (hit) check({tag, "_data"}, fwd_data, d);
        load_valid  = 1'b0;
    endtask

    initial begin
        int exp_idx;
        rst = 1'b1; flush = 1'b0; store_valid = 1'b0; store_waddr = '0; store_wdata = '0;
        store_funct3 = '0; store_rob_id = '0; commit_valid = 1'b0; commit_rob_id = '0;
        mem_wready = 1'b0; load_valid = 1'b0; load_raddr = '0; load_funct3 = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_empty", 32'(sb_empty), 32'd1);
        check("rst_full", 32'(sb_full), 32'd0);
        check("rst_wvalid", 32'(mem_wvalid), 32'd0);
        check("rst_hit", 32'(fwd_hit), 32'd0);
        check("rst_stall", 32'(fwd_stall), 32'd0);
        check("rst_cerr", 32'(commit_error), 32'd0);

        // Store -> commit -> drain latency
        mem_wready = 1'b1;
        do_store(32'h100, 32'hDEADBEEF, 3'b010, 5'd3);
        commit_valid = 1'b1; commit_rob_id = 5'd3;
        #1;
        check("lat_wvalid_n1", 32'(mem_wvalid), 32'd0);
        tick();
        commit_valid = 1'b0;
        check("lat_wvalid_n2", 32'(mem_wvalid), 32'd1);
        check("lat_addr", mem_waddr, 32'h100);
        check("lat_data", mem_wdata, 32'hDEADBEEF);
        check("lat_f3", 32'(mem_wfunct3), 32'd2);
        tick();
        check("lat_empty", 32'(sb_empty), 32'd1);
        check("lat_wvalid_off", 32'(mem_wvalid), 32'd0);

        // Forwarding
        mem_wready = 1'b0;
        do_store(32'h200, 32'h11223344, 3'b010, 5'd4);
        load_chk("lb201", 32'h201, 3'b000, 1'b1, 1'b0, 32'h00000033);
        load_chk("lbu203", 32'h203, 3'b100, 1'b1, 1'b0, 32'h00000011);
        load_chk("lh202", 32'h202, 3'b001, 1'b1, 1'b0, 32'h00001122);
        load_chk("lw200", 32'h200, 3'b010, 1'b1, 1'b0, 32'h11223344);
        do_store(32'h200, 32'h00000080, 3'b000, 5'd5);
        load_chk("lw_part", 32'h200, 3'b010, 1'b0, 1'b1, 32'h0);
        load_chk("lb_sext", 32'h200, 3'b000, 1'b1, 1'b0, 32'hFFFFFF80);
        load_chk("lb_older", 32'h201, 3'b100, 1'b0, 1'b1, 32'h0);
        load_chk("lw_miss", 32'h204, 3'b010, 1'b0, 1'b0, 32'h0);
        load_raddr = 32'h200; load_funct3 = 3'b000; #1;
        check("noload_hit", 32'(fwd_hit), 32'd0);
        check("noload_stall", 32'(fwd_stall), 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        check("fwd_flush_empty", 32'(sb_empty), 32'd1);

        // Fill to full, drop 9th store
        for (int i = 0; i < 8; i++) begin
            do_store(32'h300 + 32'(4 * i), 32'(i), 3'b010, 5'(i));
        end
        check("full_set", 32'(sb_full), 32'd1);
        do_store(32'h400, 32'hAAAA5555, 3'b010, 5'd8);
        check("full_hold", 32'(sb_full), 32'd1);
        load_chk("drop9", 32'h400, 3'b010, 1'b0, 1'b0, 32'h0);
        load_chk("last8", 32'h31C, 3'b010, 1'b1, 1'b0, 32'd7);
        do_commit(5'd0);
        check("full_wvalid", 32'(mem_wvalid), 32'd1);
        check("full_waddr", mem_waddr, 32'h300);
        // Pop and store in the same cycle while full: store dropped
        mem_wready = 1'b1;
        do_store(32'h500, 32'h55555555, 3'b010, 5'd9);
        mem_wready = 1'b0;
        check("pop_full_clr", 32'(sb_full), 32'd0);
        load_chk("pop_drop", 32'h500, 3'b010, 1'b0, 1'b0, 32'h0);
        load_chk("pop_keep", 32'h304, 3'b010, 1'b1, 1'b0, 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("full_flush_empty", 32'(sb_empty), 32'd1);

        // Flush keeps committed entries only
        do_store(32'h700, 32'hA1, 3'b010, 5'd1);
        do_store(32'h704, 32'hA2, 3'b010, 5'd2);
        do_store(32'h708, 32'hA3, 3'b010, 5'd3);
        do_commit(5'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("fl_notempty", 32'(sb_empty), 32'd0);
        load_chk("fl_gone", 32'h704, 3'b010, 1'b0, 1'b0, 32'h0);
        load_chk("fl_kept", 32'h700, 3'b010, 1'b1, 1'b0, 32'hA1);
        check("fl_wvalid", 32'(mem_wvalid), 32'd1);
        check("fl_waddr", mem_waddr, 32'h700);
        check("fl_wdata", mem_wdata, 32'hA1);
        mem_wready = 1'b1; tick(); mem_wready = 1'b0;
        check("fl_drained", 32'(sb_empty), 32'd1);

        // Commit and flush in the same cycle: committed entry survives, store ignored
        do_store(32'h710, 32'hB4, 3'b010, 5'd4);
        commit_valid = 1'b1; commit_rob_id = 5'd4; flush = 1'b1;
        store_valid = 1'b1; store_waddr = 32'h714; store_wdata = 32'hB5; store_rob_id = 5'd5;
        tick();
        commit_valid = 1'b0; flush = 1'b0; store_valid = 1'b0;
        check("cf_wvalid", 32'(mem_wvalid), 32'd1);
        check("cf_waddr", mem_waddr, 32'h710);
        load_chk("cf_ign", 32'h714, 3'b010, 1'b0, 1'b0, 32'h0);
        mem_wready = 1'b1; tick(); mem_wready = 1'b0;
        check("cf_empty", 32'(sb_empty), 32'd1);

        // Wrap-around: pipelined store/commit/drain, order preserved
        exp_idx = 0;
        mem_wready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            store_valid  = (c < 20);
            store_waddr  = 32'h800 + 32'(4 * c);
            store_wdata  = 32'h1000 + 32'(c);
            store_funct3 = 3'b010;
            store_rob_id = 5'(c);
            commit_valid  = (c >= 1) && (c <= 20);
            commit_rob_id = 5'(c - 1);
            #1;
            if (mem_wvalid) begin
                check("wrap_addr", mem_waddr, 32'h800 + 32'(4 * exp_idx));
                check("wrap_data", mem_wdata, 32'h1000 + 32'(exp_idx));
                exp_idx++;
            end
            tick();
        end
        store_valid = 1'b0; commit_valid = 1'b0; mem_wready = 1'b0;
        check("wrap_count", 32'(exp_idx), 32'd20);
        check("wrap_empty", 32'(sb_empty), 32'd1);
        check("wrap_cerr", 32'(commit_error), 32'd0);

        // Commit id mismatch: sticky error, nothing committed
        do_store(32'h600, 32'hC2, 3'b010, 5'd2);
        do_commit(5'd7);
        check("cerr_set", 32'(commit_error), 32'd1);
        check("cerr_nocommit", 32'(mem_wvalid), 32'd0);
        tick();
        check("cerr_sticky", 32'(commit_error), 32'd1);
        do_commit(5'd2);
        check("cerr_recover", 32'(mem_wvalid), 32'd1);
        check("cerr_still", 32'(commit_error), 32'd1);
        mem_wready = 1'b1; tick(); mem_wready = 1'b0;
        check("cerr_empty", 32'(sb_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of the execution stage's load/store path.
- Captures executed stores (address, data, size, ROB id) in program order and holds them speculatively until the ROB commits them.
- Drains committed stores to the data-memory write port over a valid/ready handshake.
- Forwards buffered store data to younger loads issued from the same execution stage; discards uncommitted stores on flush.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
ROB_WIDTH, 5, ROB id width
SB_DEPTH, 8, entries; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  mispredict flush; drop uncommitted entries
store_valid  in  1  executed store present
store_waddr  in  ADDR_WIDTH  store address
store_wdata  in  DATA_WIDTH  store data (unaligned, low bits valid)
store_funct3  in  3  SB=000, SH=001, SW=010
store_rob_id  in  ROB_WIDTH  store ROB id
commit_valid  in  1  ROB head is a store retiring this cycle
commit_rob_id  in  ROB_WIDTH  its ROB id
mem_wvalid  out  1  write request
mem_waddr  out  ADDR_WIDTH  write address
mem_wdata  out  DATA_WIDTH  write data
mem_wfunct3  out  3  write size
mem_wready  in  1  memory accepts write
load_valid  in  1  load lookup request
load_raddr  in  ADDR_WIDTH  load address
load_funct3  in  3  load size/sign
fwd_hit  out  1  forwarded data valid
fwd_data  out  DATA_WIDTH  forwarded, sign/zero-extended
fwd_stall  out  1  partial overlap; load must replay
sb_full  out  1  count == SB_DEPTH
sb_empty  out  1  count == 0
commit_error  out  1  sticky; commit id mismatch

Behaviour:
- Circular buffer; registers head (oldest), cmt (oldest uncommitted), tail, count (log2(SB_DEPTH)+1 bits).
- Entry fields: valid, committed, addr, data, funct3, rob_id.
- Reset: all pointers and count 0, every entry valid=0, commit_error=0. Outputs mem_wvalid, fwd_hit, fwd_stall = 0; sb_empty=1; sb_full=0.
- Allocate: store_valid && !sb_full && !flush writes the entry at tail, tail+1. sb_full comes from registered count; no allocation when full, even if a pop occurs that cycle. store_valid while full: store is dropped. Upstream must hold the store off via sb_full.
- Commit: on commit_valid, commit_rob_id must equal entry[cmt].rob_id with entry[cmt].valid. On match, set committed and advance cmt. On mismatch or empty, set commit_error (sticky until rst) and change no state.
- Drain: mem_wvalid = entry[head].valid && entry[head].committed (combinational from registers). mem_* driven from entry[head]. On mem_wvalid && mem_wready, clear the entry and advance head.
- Flush: tail <= cmt; entries from cmt to tail-1 are invalidated; count = committed entries remaining. A same-cycle commit is applied first (the committed entry survives). A same-cycle drain handshake completes normally. A same-cycle store_valid is ignored.
- Count update: +1 on alloc, -1 on pop, both simultaneously leaves it unchanged. Pointers wrap modulo SB_DEPTH.
- Latency: store at cycle N is forwardable at N+1. Earliest commit is N+1; earliest mem_wvalid is N+2.
- Forwarding (combinational, same cycle as load_valid):
  - Scan valid entries youngest to oldest.
  - The first entry whose word address (addr[ADDR_WIDTH-1:2]) matches decides the result.
  - If that entry exactly covers the load, fwd_hit=1: its byte range contains the load range, from addr[1:0] and size.
  - fwd_data = extracted bytes, extended per load_funct3 (LB/LH sign, LBU/LHU zero, LW).
  - Otherwise fwd_stall=1.
  - No match, or load_valid=0: both outputs 0.
  - fwd_hit and fwd_stall are never both 1.
- Store data is stored unaligned. On forwarding it is shifted by (load_addr-store_addr) bytes.

Decomposition:
- parameter_pkg: SB_DEPTH default, funct3 constants SB/SH/SW, LB/LH/LW/LBU/LHU.
- typedef_pkg: SB_ENTRY_t packed struct {valid, committed, addr, data, funct3, rob_id}.
- One sub-module: sb_forward_unit. It is combinational: entry array, head, count, load request in; fwd_hit, fwd_data, fwd_stall out. Its youngest-first priority scan and byte extraction are kept separate from the sequential pointer logic.

Test Plan:
- Reset, then SW 0x100=0xDEADBEEF rob 3; commit rob 3 next cycle, mem_wready=1 -> mem_wvalid at N+2 with addr 0x100, data 0xDEADBEEF, funct3 010; sb_empty=1 after.
- SW 0x200=0x11223344, then LB 0x201 -> fwd_hit=1, fwd_data=0x00000033. LBU 0x203 -> 0x00000011. SB 0x200=0x80 then LW 0x200 -> fwd_stall=1.
- Fill 8 stores, no commits -> sb_full=1. 9th store_valid -> dropped, count stays 8, tail unchanged.
- Stores rob 1,2,3; commit rob 1; flush with mem_wready=0 -> only rob 1 remains (count=1). Later drain writes only rob 1's store.
- Commit rob 7 when cmt entry has rob 2 -> commit_error=1 persists; no entry committed.
- Full buffer, mem_wready=1 and store_valid same cycle -> pop occurs, store dropped, count 7. Wrap-around: 20 store/commit/drain cycles -> memory sees writes in original order.
